// File: rtl/rom_stream_sequencer.sv
// Streams the contents of an asynchronous single-port ROM onto a valid/ready output.
// Supports one-shot or looping passes over addresses 0..LAST_ADDR, with a graceful stop.
module rom_stream_sequencer #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 3,
  parameter int unsigned LAST_ADDR  = 2**ADDR_WIDTH - 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  loop,
  input  logic                  stop,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_q,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH:0]   word_count
);

  localparam int unsigned CNT_WIDTH = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(LAST_ADDR);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_rom_addr;
  logic [DATA_WIDTH-1:0] r_m_data;
  logic                  r_m_valid;
  logic                  r_busy;
  logic                  r_done;
  logic [CNT_WIDTH-1:0]  r_word_count;
  logic                  r_stop_req;

  state_t                w_state;
  logic [ADDR_WIDTH-1:0] w_rom_addr;
  logic [DATA_WIDTH-1:0] w_m_data;
  logic                  w_m_valid;
  logic                  w_busy;
  logic                  w_done;
  logic [CNT_WIDTH-1:0]  w_word_count;
  logic                  w_stop_req;
  logic                  w_xfer;

  assign w_xfer = r_m_valid & m_ready;

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_rom_addr   <= '0;
      r_m_data     <= '0;
      r_m_valid    <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_word_count <= '0;
      r_stop_req   <= 1'b0;
    end else begin
      r_state      <= w_state;
      r_rom_addr   <= w_rom_addr;
      r_m_data     <= w_m_data;
      r_m_valid    <= w_m_valid;
      r_busy       <= w_busy;
      r_done       <= w_done;
      r_word_count <= w_word_count;
      r_stop_req   <= w_stop_req;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    w_state      = r_state;
    w_rom_addr   = r_rom_addr;
    w_m_data     = r_m_data;
    w_m_valid    = r_m_valid;
    w_busy       = r_busy;
    w_done       = 1'b0;
    w_word_count = r_word_count;
    w_stop_req   = r_stop_req;

    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state      = S_FETCH;
          w_rom_addr   = '0;
          w_word_count = '0;
          w_stop_req   = 1'b0;
          w_busy       = 1'b1;
        end
      end
      S_FETCH: begin
        // rom_q is already valid for the registered address, so capture directly
        w_m_data  = rom_q;
        w_m_valid = 1'b1;
        w_state   = S_HOLD;
        if (stop) w_stop_req = 1'b1;
      end
      S_HOLD: begin
        if (w_xfer) begin
          w_word_count = r_word_count + CNT_WIDTH'(1);
          w_m_valid    = 1'b0;
          if (r_stop_req || stop) begin
            w_state = S_IDLE;
            w_done  = 1'b1;
            w_busy  = 1'b0;
          end else if (r_rom_addr != LAST) begin
            w_rom_addr = r_rom_addr + ADDR_WIDTH'(1);
            w_state    = S_FETCH;
          end else if (loop) begin
            w_rom_addr = '0;
            w_state    = S_FETCH;
          end else begin
            w_rom_addr = '0;
            w_state    = S_IDLE;
            w_done     = 1'b1;
            w_busy     = 1'b0;
          end
        end else if (stop) begin
          w_stop_req = 1'b1;
        end
      end
      default: begin
        w_state   = S_IDLE;
        w_m_valid = 1'b0;
        w_busy    = 1'b0;
      end
    endcase
  end

  assign rom_addr   = r_rom_addr;
  assign m_data     = r_m_data;
  assign m_valid    = r_m_valid;
  assign busy       = r_busy;
  assign done       = r_done;
  assign word_count = r_word_count;

endmodule

// File: tb/tb_rom_stream_sequencer.sv
// Directed bench for rom_stream_sequencer: full-range instance plus a LAST_ADDR=0 instance.
// ROM model in both cases is rom[i] = 8'hA0 + i.
module tb_rom_stream_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       loop, stop, m_ready;

  logic       start0;
  logic [2:0] rom_addr0;
  logic [7:0] rom_q0, m_data0;
  logic       m_valid0, busy0, done0;
  logic [3:0] word_count0;

  logic       start1;
  logic [2:0] rom_addr1;
  logic [7:0] rom_q1, m_data1;
  logic       m_valid1, busy1, done1;
  logic [3:0] word_count1;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  assign rom_q0 = 8'hA0 + 8'(rom_addr0);
  assign rom_q1 = 8'hA0 + 8'(rom_addr1);

  rom_stream_sequencer #(.DATA_WIDTH(8), .ADDR_WIDTH(3)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .loop(loop), .stop(stop),
    .rom_addr(rom_addr0), .rom_q(rom_q0), .m_data(m_data0), .m_valid(m_valid0),
    .m_ready(m_ready), .busy(busy0), .done(done0), .word_count(word_count0)
  );

  rom_stream_sequencer #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .LAST_ADDR(0)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .loop(loop), .stop(stop),
    .rom_addr(rom_addr1), .rom_q(rom_q1), .m_data(m_data1), .m_valid(m_valid1),
    .m_ready(m_ready), .busy(busy1), .done(done1), .word_count(word_count1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_word0(input string tag, input logic [7:0] exp);
    check({tag, "_valid"}, 32'(m_valid0), 32'd1);
    check({tag, "_data"},  32'(m_data0),  32'(exp));
  endtask

  initial begin
    rst_n = 1'b0; start0 = 1'b0; start1 = 1'b0;
    loop = 1'b0; stop = 1'b0; m_ready = 1'b0;
    #3;
    check("rst_valid", 32'(m_valid0), 32'd0);
    check("rst_busy",  32'(busy0),    32'd0);
    check("rst_done",  32'(done0),    32'd0);
    check("rst_addr",  32'(rom_addr0), 32'd0);
    check("rst_data",  32'(m_data0),  32'd0);
    check("rst_wc",    32'(word_count0), 32'd0);
    #9 rst_n = 1'b1;
    step();

    // 1. one-shot pass
    start0 = 1'b1;
    step();
    check("t1_busy", 32'(busy0), 32'd1);
    check("t1_fetch_valid", 32'(m_valid0), 32'd0);
    start0 = 1'b0; m_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      check_word0("t1_word", 8'(8'hA0 + i));
      step();
      check("t1_wc", 32'(word_count0), 32'(i + 1));
      check("t1_valid_drop", 32'(m_valid0), 32'd0);
      check("t1_done", 32'(done0), (i == 7) ? 32'd1 : 32'd0);
      check("t1_busy_run", 32'(busy0), (i == 7) ? 32'd0 : 32'd1);
    end
    check("t1_end_addr", 32'(rom_addr0), 32'd0);
    step();
    check("t1_done_pulse", 32'(done0), 32'd0);

    // 2. backpressure on A3
    start0 = 1'b1;
    step();
    start0 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      check_word0("t2_word", 8'(8'hA0 + i));
      if (i == 3) begin
        m_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
          step();
          check_word0("t2_hold", 8'hA3);
          check("t2_hold_wc", 32'(word_count0), 32'd3);
        end
        m_ready = 1'b1;
      end
      step();
      check("t2_wc", 32'(word_count0), 32'(i + 1));
    end
    check("t2_done", 32'(done0), 32'd1);

    // 3. loop with counter wrap
    loop = 1'b1;
    start0 = 1'b1;
    step();
    start0 = 1'b0;
    for (int j = 0; j < 16; j++) begin
      step();
      check_word0("t3_word", 8'(8'hA0 + (j % 8)));
      step();
      check("t3_wc", 32'(word_count0), 32'((j + 1) % 16));
      check("t3_no_done", 32'(done0), 32'd0);
      check("t3_busy", 32'(busy0), 32'd1);
    end
    step();
    check_word0("t3_wrap_word", 8'hA0);
    stop = 1'b1;
    step();
    stop = 1'b0; loop = 1'b0;
    check("t3_stop_done", 32'(done0), 32'd1);
    check("t3_stop_wc", 32'(word_count0), 32'd1);
    check("t3_stop_busy", 32'(busy0), 32'd0);

    // 4. stop during fetch of A2 with backpressure
    start0 = 1'b1;
    step();
    start0 = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      check_word0("t4_word", 8'(8'hA0 + i));
      step();
    end
    check("t4_fetch_addr", 32'(rom_addr0), 32'd2);
    stop = 1'b1; m_ready = 1'b0;
    step();
    stop = 1'b0;
    check_word0("t4_a2", 8'hA2);
    for (int k = 0; k < 2; k++) begin
      step();
      check_word0("t4_a2_hold", 8'hA2);
    end
    m_ready = 1'b1;
    step();
    check("t4_done", 32'(done0), 32'd1);
    check("t4_busy", 32'(busy0), 32'd0);
    check("t4_valid", 32'(m_valid0), 32'd0);
    check("t4_wc", 32'(word_count0), 32'd3);
    for (int k = 0; k < 3; k++) begin
      step();
      check("t4_no_a3", 32'(m_valid0), 32'd0);
      check("t4_done_once", 32'(done0), 32'd0);
    end

    // 5. ignored start mid-pass, then async reset
    start0 = 1'b1;
    step();
    start0 = 1'b0;
    step();
    check_word0("t5_a0", 8'hA0);
    step();
    step();
    check_word0("t5_a1", 8'hA1);
    start0 = 1'b1;
    step();
    step();
    start0 = 1'b0;
    check_word0("t5_a2", 8'hA2);
    check("t5_wc", 32'(word_count0), 32'd2);
    check("t5_addr", 32'(rom_addr0), 32'd2);
    m_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("t5_rst_valid", 32'(m_valid0), 32'd0);
    check("t5_rst_busy",  32'(busy0),    32'd0);
    check("t5_rst_addr",  32'(rom_addr0), 32'd0);
    check("t5_rst_data",  32'(m_data0),  32'd0);
    check("t5_rst_wc",    32'(word_count0), 32'd0);
    step();
    check("t5_rst_no_done", 32'(done0), 32'd0);
    rst_n = 1'b1;
    step();
    check("t5_post_done", 32'(done0), 32'd0);
    check("t5_post_busy", 32'(busy0), 32'd0);

    // 6. single-word passes, LAST_ADDR = 0
    m_ready = 1'b1;
    start1 = 1'b1;
    step();
    start1 = 1'b0;
    step();
    check("t6_valid", 32'(m_valid1), 32'd1);
    check("t6_data",  32'(m_data1),  32'hA0);
    step();
    check("t6_done", 32'(done1), 32'd1);
    check("t6_busy", 32'(busy1), 32'd0);
    check("t6_wc",   32'(word_count1), 32'd1);
    check("t6_addr", 32'(rom_addr1), 32'd0);
    loop = 1'b1;
    start1 = 1'b1;
    step();
    start1 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      check("t6_loop_valid", 32'(m_valid1), 32'd1);
      check("t6_loop_data",  32'(m_data1),  32'hA0);
      check("t6_loop_addr",  32'(rom_addr1), 32'd0);
      if (k == 2) loop = 1'b0;
      step();
      check("t6_loop_done", 32'(done1), (k == 2) ? 32'd1 : 32'd0);
      check("t6_loop_busy", 32'(busy1), (k == 2) ? 32'd0 : 32'd1);
    end
    check("t6_loop_wc", 32'(word_count1), 32'd3);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
    $finish;
  end

endmodule
